program_fetch: RTL and testbench

Instruction-byte prefetch unit for the 8051 core. It sits between the synchronous program ROM and the instruction decoder. It drives ROM read addresses from an internal fetch PC and buffers the returned bytes in a small FIFO. It presents the bytes in order to the decoder over a valid/ready handshake. A jump request from the core flushes the buffer and restarts fetching at a new address.

---
 rtl/program_fetch.sv | 113 +++++++++++
 tb/tb_program_fetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_fetch.sv
// Instruction-byte prefetch unit: issues ROM reads from a fetch PC and queues {byte, pc} for the decoder.
// Optional FETCH_BYPASS_EN forwards a response straight to the outputs when the FIFO is empty.
module program_fetch #(
  parameter int unsigned                ADDR_WIDTH   = 16,
  parameter int unsigned                DATA_WIDTH   = 8,
  parameter int unsigned                DEPTH        = 4,
  parameter logic [ADDR_WIDTH-1:0]      RESET_VECTOR = 16'h0000
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  jump_valid,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic [DATA_WIDTH-1:0] byte_data,
  output logic [ADDR_WIDTH-1:0] byte_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [ADDR_WIDTH-1:0] fetch_pc, pending_pc;
  logic                  pending;
  logic [DATA_WIDTH-1:0] last_data;
  logic [ADDR_WIDTH-1:0] last_pc;

  logic                  fifo_empty, bypass, issue, push, pop, pop_fifo;
  logic [CNT_W:0]        in_use;

  assign rom_addr   = fetch_pc;
  assign fifo_empty = (count == '0);
  // Outstanding reads are credited against FIFO space so a response always has a slot.
  assign in_use     = {1'b0, count} + {{CNT_W{1'b0}}, pending};
  assign issue      = !jump_valid && (in_use < DEPTH_C);

  always_comb begin
    bypass = 1'b0;
`ifdef FETCH_BYPASS_EN
    bypass = fifo_empty && pending && !jump_valid;
`endif
    if (bypass) begin
      byte_valid = 1'b1;
      byte_data  = rom_data;
      byte_pc    = pending_pc;
    end else if (!fifo_empty) begin
      byte_valid = 1'b1;
      byte_data  = mem_data[rd_ptr];
      byte_pc    = mem_pc[rd_ptr];
    end else begin
      byte_valid = 1'b0;
      byte_data  = last_data;
      byte_pc    = last_pc;
    end
    pop      = byte_valid && byte_ready && !jump_valid;
    pop_fifo = pop && !bypass;
    // A bypassed byte consumed this cycle never enters the FIFO.
    push     = pending && !jump_valid && !(bypass && byte_ready);
  end

  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_data[wr_ptr] <= rom_data;
      mem_pc[wr_ptr]   <= pending_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc   <= RESET_VECTOR;
      pending    <= 1'b0;
      pending_pc <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_data  <= '0;
      last_pc    <= '0;
    end else begin
      pending <= issue;
      if (issue) begin
        pending_pc <= fetch_pc;
        fetch_pc   <= fetch_pc + 1'b1;
      end
      if (jump_valid) begin
        fetch_pc <= jump_addr;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop_fifo)
          rd_ptr <= rd_ptr + 1'b1;
        unique case ({push, pop_fifo})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      if (pop) begin
        last_data <= byte_data;
        last_pc   <= byte_pc;
      end
    end
  end

endmodule

// File: tb/tb_program_fetch.sv
// Self-checking bench for program_fetch: directed scenarios plus random ready/jump traffic
// checked against an in-order stream model (next expected pc, ROM contents, latency bounds).
module tb_program_fetch;

  logic        clock;
  logic        reset;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        jump_valid;
  logic [15:0] jump_addr;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic [15:0] byte_pc;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  program_fetch #(
    .ADDR_WIDTH  (16),
    .DATA_WIDTH  (8),
    .DEPTH       (4),
    .RESET_VECTOR(16'h0000)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .jump_valid(jump_valid),
    .jump_addr (jump_addr),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .byte_data (byte_data),
    .byte_pc   (byte_pc)
  );

  logic [7:0] rom [65536];

  always #5 clock = ~clock;

  always @(posedge clock) rom_data <= rom[rom_addr];

  int          tests = 0;
  int          fails = 0;
  int          pops  = 0;
  int          stall = 0;
  bit          chk_stall = 0;
  logic [15:0] exp_pc;
  logic [15:0] popped_q[$];
  logic [15:0] jtarget;
  logic [15:0] e;
  int          k;
  int          pops_before;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: between redirects the accepted bytes are ROM[pc] at strictly consecutive pcs.
  task automatic step();
    if (!reset && !jump_valid && byte_ready) begin
      if (byte_valid) begin
        check("pop_pc", byte_pc, exp_pc);
        check("pop_data", byte_data, rom[exp_pc]);
        popped_q.push_back(byte_pc);
        exp_pc = exp_pc + 16'd1;
        pops++;
        stall = 0;
      end else if (chk_stall) begin
        stall++;
        check("stall_bound", (stall <= LAT) ? 1 : 0, 1);
      end
    end
    if (jump_valid) begin
      exp_pc = jump_addr;
      stall  = 0;
    end
    @(posedge clock);
    #1;
    if (reset) begin
      exp_pc = 16'h0000;
      stall  = 0;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!byte_valid && n < 10) begin
      step();
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clock      = 0;
    reset      = 1;
    jump_valid = 0;
    jump_addr  = 16'h0000;
    byte_ready = 0;
    exp_pc     = 16'h0000;
    for (int i = 0; i < 65536; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h02; rom[1] = 8'h00; rom[2] = 8'h30; rom[3] = 8'hE4;
    step();
    step();

    // Reset state
    check("rst_valid", byte_valid, 0);
    check("rst_data", byte_data, 0);
    check("rst_pc", byte_pc, 0);
    check("rst_rom_addr", rom_addr, 16'h0000);

    // Stream from reset vector with ready held high
    byte_ready = 1;
    reset      = 0;
    popped_q.delete();
    wait_valid(k);
    check("t1_latency", k, LAT);
    for (int i = 0; i < 4; i++) begin
      check("t1_back_to_back", byte_valid, 1);
      step();
    end
    check("t1_count", popped_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t1_pc_seq", popped_q[i], i);

    // Backpressure: FIFO fills and fetching stalls
    reset = 1;
    step();
    reset      = 0;
    byte_ready = 0;
    repeat (10) step();
    check("t2_rom_addr_stall", rom_addr, 16'h0004);
    check("t2_valid_full", byte_valid, 1);
    check("t2_head_pc", byte_pc, 16'h0000);
    byte_ready = 1;
    popped_q.delete();
    repeat (6) step();
    check("t2_drain_count", popped_q.size(), 6);
    check("t2_resume_pc", exp_pc, 16'h0006);

    // Jump while the FIFO holds 3 bytes
    reset = 1;
    step();
    reset      = 0;
    byte_ready = 0;
    repeat (4) step();
    check("t3_rom_addr", rom_addr, 16'h0004);
    check("t3_holding", byte_valid, 1);
    jump_valid = 1;
    jump_addr  = 16'h0100;
    step();
    jump_valid = 0;
    check("t3_rom_addr_jump", rom_addr, 16'h0100);
    byte_ready = 1;
    wait_valid(k);
    check("t3_latency", k, LAT);
    check("t3_first_pc", byte_pc, 16'h0100);
    check("t3_first_data", byte_data, rom[16'h0100]);
    repeat (5) step();

    // Jump with a pop and an in-flight response in the same cycle
    check("t4_streaming", byte_valid, 1);
    jtarget    = 16'($urandom);
    jump_valid = 1;
    jump_addr  = jtarget;
    step();
    jump_valid = 0;
    wait_valid(k);
    check("t4_latency", k, LAT);
    check("t4_first_pc", byte_pc, jtarget);
    repeat (4) step();

    // Address wrap
    jump_valid = 1;
    jump_addr  = 16'hFFFE;
    step();
    jump_valid = 0;
    wait_valid(k);
    popped_q.delete();
    repeat (4) step();
    check("t5_count", popped_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      e = 16'hFFFE + 16'(i);
      if (i < popped_q.size()) check("t5_wrap_pc", popped_q[i], e);
    end

    // Reset mid-stream with FIFO partly full
    byte_ready = 0;
    repeat (2) step();
    reset = 1;
    step();
    check("t6_valid", byte_valid, 0);
    check("t6_rom_addr", rom_addr, 16'h0000);
    check("t6_pc", byte_pc, 16'h0000);
    check("t6_data", byte_data, 8'h00);
    reset      = 0;
    byte_ready = 1;
    wait_valid(k);
    check("t6_latency", k, LAT);
    check("t6_first_pc", byte_pc, 16'h0000);
    check("t6_first_data", byte_data, 8'h02);
    repeat (4) step();

    // Random ready and jumps
    jump_valid = 1;
    jump_addr  = 16'($urandom);
    step();
    chk_stall   = 1;
    pops_before = pops;
    for (int i = 0; i < 3000; i++) begin
      byte_ready = ($urandom_range(0, 3) != 0);
      jump_valid = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0)
        jump_addr = 16'hFFFC + 16'($urandom_range(0, 3));
      else
        jump_addr = 16'($urandom);
      step();
    end
    jump_valid = 0;
    check("rand_progress", (pops - pops_before > 1000) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
